// File: rtl/seg7_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment clock display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   // Power-on time shown until the first frame-boundary snapshot: 12:00:00 AM.
   localparam logic [7:0] SNAP_HH_RST = 8'h12;
   localparam logic [7:0] SNAP_MM_RST = 8'h00;
   localparam logic [7:0] SNAP_SS_RST = 8'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles (10..15) show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_DASH;
      case (bcd)
         4'd0: seg_n = SEG_0;
         4'd1: seg_n = SEG_1;
         4'd2: seg_n = SEG_2;
         4'd3: seg_n = SEG_3;
         4'd4: seg_n = SEG_4;
         4'd5: seg_n = SEG_5;
         4'd6: seg_n = SEG_6;
         4'd7: seg_n = SEG_7;
         4'd8: seg_n = SEG_8;
         4'd9: seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with frame-coherent time snapshot.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks a leading zero in the hours tens digit.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEAD     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic [7:0] hh,
   input  logic [7:0] mm,
   input  logic [7:0] ss,
   input  logic       pm,
   output logic [5:0] an_n,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic       frame_done
);

   localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
   localparam logic [15:0] DEAD_CNT = 16'(DEAD);
   localparam logic [2:0]  IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  snap_hh;
   logic [7:0]  snap_mm;
   logic [7:0]  snap_ss;
   logic        snap_pm;

   logic [3:0]  nib;
   logic [6:0]  seg_dec;
   logic        slot_end;
   logic        frame_end;
   logic        blank;
   logic        digit_on;
   logic [5:0]  an_nxt;
   logic [6:0]  seg_nxt;
   logic        dp_nxt;

   always_comb begin
      nib = snap_hh[7:4];
      case (idx)
         3'd0: nib = snap_ss[3:0];
         3'd1: nib = snap_ss[7:4];
         3'd2: nib = snap_mm[3:0];
         3'd3: nib = snap_mm[7:4];
         3'd4: nib = snap_hh[3:0];
         default: nib = snap_hh[7:4];
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd   (nib),
      .seg_n (seg_dec)
   );

   always_comb begin
      slot_end  = (cnt == CNT_LAST);
      frame_end = slot_end && (idx == IDX_LAST);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      blank = (idx == IDX_LAST) && (snap_hh[7:4] == 4'd0);
`else
      blank = 1'b0;
`endif
      // The first DEAD cycles of every slot keep all anodes off so the
      // previous digit's segments cannot ghost onto the new digit.
      digit_on = (cnt >= DEAD_CNT) && !blank;
      an_nxt   = 6'h3F;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_on && (idx == 3'(i))) an_nxt[i] = 1'b0;
      end
      seg_nxt = digit_on ? seg_dec : SEG_OFF;
      dp_nxt  = !(digit_on && (idx == 3'd0) && snap_pm);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         snap_hh    <= SNAP_HH_RST;
         snap_mm    <= SNAP_MM_RST;
         snap_ss    <= SNAP_SS_RST;
         snap_pm    <= 1'b0;
         an_n       <= 6'h3F;
         seg_n      <= SEG_OFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else if (ena) begin
         if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
         end else begin
            cnt <= cnt + 16'd1;
         end
         // Snapshot only at the frame boundary so a frame never mixes two times.
         if (frame_end) begin
            snap_hh <= hh;
            snap_mm <= mm;
            snap_ss <= ss;
            snap_pm <= pm;
         end
         an_n       <= an_nxt;
         seg_n      <= seg_nxt;
         dp_n       <= dp_nxt;
         frame_done <= frame_end;
      end else begin
         an_n       <= 6'h3F;
         seg_n      <= SEG_OFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random stimulus,
// compared cycle by cycle against a frame-position reference model.
module tb_seg7_scan_driver;

   localparam int SD = 8;
   localparam int DT = 2;
   localparam int FR = 6 * SD;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ena = 1'b0;
   logic [7:0] hh = 8'h00;
   logic [7:0] mm = 8'h00;
   logic [7:0] ss = 8'h00;
   logic       pm = 1'b0;
   logic [5:0] an_n;
   logic [6:0] seg_n;
   logic       dp_n;
   logic       frame_done;

   always #5 clk = ~clk;

   seg7_scan_driver #(.SCAN_DIV(SD), .DEAD(DT)) dut (
      .clk        (clk),
      .reset      (reset),
      .ena        (ena),
      .hh         (hh),
      .mm         (mm),
      .ss         (ss),
      .pm         (pm),
      .an_n       (an_n),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .frame_done (frame_done)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: position within the frame plus the latched time.
   int         pos = 0;
   logic [7:0] s_hh = 8'h12;
   logic [7:0] s_mm = 8'h00;
   logic [7:0] s_ss = 8'h00;
   logic       s_pm = 1'b0;
   logic [6:0] seg_tab [16];

   logic [6:0] seen_seg [6];
   logic       seen_dp [6];
   int         on_cnt [6];
   int         cyc = 0;
   int         last_fd = 0;
   int         fd_gap = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 6; i++) begin
         seen_seg[i] = 7'h7F;
         seen_dp[i]  = 1'b1;
         on_cnt[i]   = 0;
      end
   endtask

   task automatic tick();
      logic [5:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp;
      logic        e_fd;
      logic [23:0] word;
      logic [3:0]  nib;
      logic        on;
      int          di;
      int          c;
      e_an  = 6'h3F;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_fd  = 1'b0;
      if (!reset && ena) begin
         di   = pos / SD;
         c    = pos % SD;
         word = {s_hh, s_mm, s_ss};
         nib  = word[4*di +: 4];
         on   = (c >= DT);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         if (di == 5 && s_hh[7:4] == 4'd0) on = 1'b0;
`endif
         if (on) begin
            e_an[di] = 1'b0;
            e_seg    = seg_tab[nib];
            e_dp     = !(di == 0 && s_pm);
         end
         e_fd = (pos == FR - 1);
      end
      @(posedge clk);
      #1;
      cyc++;
      check_eq("an_n", 32'(an_n), 32'(e_an));
      check_eq("seg_n", 32'(seg_n), 32'(e_seg));
      check_eq("dp_n", 32'(dp_n), 32'(e_dp));
      check_eq("frame_done", 32'(frame_done), 32'(e_fd));
      for (int i = 0; i < 6; i++) begin
         if (an_n[i] == 1'b0) begin
            seen_seg[i] = seg_n;
            seen_dp[i]  = dp_n;
            on_cnt[i]++;
         end
      end
      if (frame_done) begin
         fd_gap  = cyc - last_fd;
         last_fd = cyc;
      end
      if (reset) begin
         pos  = 0;
         s_hh = 8'h12;
         s_mm = 8'h00;
         s_ss = 8'h00;
         s_pm = 1'b0;
      end else if (ena) begin
         if (pos == FR - 1) begin
            s_hh = hh;
            s_mm = mm;
            s_ss = ss;
            s_pm = pm;
         end
         pos = (pos + 1) % FR;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      clear_seen();

      reset = 1'b1;
      run(3);
      check_eq("rst_an_n", 32'(an_n), 32'h3F);
      check_eq("rst_seg_n", 32'(seg_n), 32'h7F);
      check_eq("rst_dp_n", 32'(dp_n), 32'h1);
      check_eq("rst_frame_done", 32'(frame_done), 32'h0);

      // Full frames with a fixed time, then inspect the second frame.
      reset = 1'b0;
      ena   = 1'b1;
      hh = 8'h07; mm = 8'h45; ss = 8'h59; pm = 1'b1;
      last_fd = cyc;
      run(FR);
      check_eq("fd_first_gap", 32'(fd_gap), 32'(FR));
      clear_seen();
      run(FR);
      check_eq("fd_gap", 32'(fd_gap), 32'(FR));
      check_eq("frm_d0", 32'(seen_seg[0]), 32'(7'b0010000));
      check_eq("frm_d1", 32'(seen_seg[1]), 32'(7'b0010010));
      check_eq("frm_d2", 32'(seen_seg[2]), 32'(7'b0010010));
      check_eq("frm_d3", 32'(seen_seg[3]), 32'(7'b0011001));
      check_eq("frm_d4", 32'(seen_seg[4]), 32'(7'b1111000));
      check_eq("frm_dp0", 32'(seen_dp[0]), 32'h0);
      check_eq("frm_dp1", 32'(seen_dp[1]), 32'h1);
      for (int i = 0; i < 5; i++) check_eq("on_cycles", 32'(on_cnt[i]), 32'(SD - DT));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check_eq("frm_d5_blank", 32'(on_cnt[5]), 32'h0);
`else
      check_eq("frm_d5", 32'(seen_seg[5]), 32'(7'b1000000));
      check_eq("frm_d5_on", 32'(on_cnt[5]), 32'(SD - DT));
`endif

      // Mid-frame seconds change must not tear the frame.
      ss = 8'h30;
      run(FR);
      clear_seen();
      run(2 * SD + 3);
      ss = 8'h31;
      run(FR - 2 * SD - 3);
      check_eq("tear_cur", 32'(seen_seg[0]), 32'(7'b1000000));
      clear_seen();
      run(FR);
      check_eq("tear_next", 32'(seen_seg[0]), 32'(7'b1111001));

      // Non-decimal nibble shows a dash.
      ss = 8'h5C;
      run(FR);
      clear_seen();
      run(SD + 1);
      check_eq("dash", 32'(seen_seg[0]), 32'(7'b0111111));

      // Pause at idx 3, cnt 5, then resume.
      while (pos != 3 * SD + 5) tick();
      ena = 1'b0;
      run(20);
      check_eq("pause_an_n", 32'(an_n), 32'h3F);
      check_eq("pause_pos", 32'(pos), 32'(3 * SD + 5));
      ena = 1'b1;
      clear_seen();
      run(3);
      check_eq("resume_slot3", 32'(on_cnt[3]), 32'h3);
      tick();
      check_eq("resume_dead", 32'(an_n), 32'h3F);

      // Leading zero in the hours tens digit.
      hh = 8'h01;
      while (pos != 0) tick();
      clear_seen();
      run(FR);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check_eq("lz_blank", 32'(on_cnt[5]), 32'h0);
`else
      check_eq("lz_shown", 32'(seen_seg[5]), 32'(7'b1000000));
      check_eq("lz_on", 32'(on_cnt[5]), 32'(SD - DT));
`endif

      // Random traffic: enable gaps, input changes, occasional reset.
      for (int k = 0; k < 3000; k++) begin
         ena   = ($urandom_range(0, 9) != 0);
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) begin
            hh = 8'($urandom);
            mm = 8'($urandom);
            ss = 8'($urandom);
            pm = 1'($urandom);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles per digit slot; legal range 8..65535.
REQ-002 SHALL have parameter DEAD, default 4, blanking cycles at the start of each slot; legal range 1..SCAN_DIV-1.
REQ-003 SHALL use clock clk; reset is reset, synchronous, active-high.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 ena  input  1  display enable.
REQ-007 hh  input  8  hours BCD {tens,ones}.
REQ-008 mm  input  8  minutes BCD.
REQ-009 ss  input  8  seconds BCD.
REQ-010 pm  input  1  PM indicator.
REQ-011 an_n  output  6  digit enables, active-low; bit i = digit i.
REQ-012 seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 dp_n  output  1  decimal point, active-low.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each 6-digit frame.

Function
REQ-015 SHALL count prescaler cnt 0..SCAN_DIV-1 while ena=1; at SCAN_DIV-1, cnt wraps to 0 and digit index idx advances 0..5, wrapping 5->0.
REQ-016 Digit map SHALL be: idx0=ss[3:0], idx1=ss[7:4], idx2=mm[3:0], idx3=mm[7:4], idx4=hh[3:0], idx5=hh[7:4], all taken from the snapshot registers.
REQ-017 SHALL load snapshot registers (hh, mm, ss, pm) from the inputs in the cycle where ena=1, idx=5 and cnt=SCAN_DIV-1; no other update, so a frame never tears.
REQ-018 frame_done SHALL be 1 in the cycle after the snapshot load cycle; otherwise 0.
REQ-019 All outputs SHALL be registered; outputs in cycle t+1 reflect cnt/idx/snapshot in cycle t.
REQ-020 an_n[idx] SHALL be 0 only when cnt>=DEAD; all other an_n bits SHALL be 1 (anti-ghosting dead time).
REQ-021 Decoder SHALL map 0..9 to standard patterns (e.g. 0 -> seg_n=7'b1000000, 1 -> 7'b1111001); nibble 10..15 SHALL display '-' (seg_n=7'b0111111).
REQ-022 dp_n SHALL be 0 only when idx=0, pm snapshot=1 and the digit is enabled; otherwise 1.
REQ-023 While ena=0: cnt, idx and snapshot SHALL hold; an_n=6'h3F, seg_n=7'h7F, dp_n=1, frame_done=0 from the next cycle.
REQ-024 Re-asserting ena SHALL resume from the held cnt/idx without skipping or repeating a slot.

Reset
REQ-025 On reset: cnt=0, idx=0, snapshot hh=8'h12, mm=8'h00, ss=8'h00, pm=0.
REQ-026 Outputs one cycle after reset SHALL be an_n=6'h3F, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-027 Reset asserted mid-slot or mid-frame SHALL take priority over ena and all counting.

Configuration
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN defined: when idx=5 and hh tens nibble=0, that digit SHALL be blanked (an_n bit 5 kept at 1 for the whole slot).
REQ-029 Macro SEG7_LEADING_ZERO_BLANK_EN undefined: the hh tens digit SHALL always be displayed, '0' included.

Structure
REQ-030 Package seg7_pkg SHALL hold NUM_DIGITS=6, the 7-bit segment constants for 0..9, SEG_DASH and SEG_OFF.
REQ-031 A combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out) SHALL implement REQ-021; the top level instantiates it once.

Verification
REQ-032 SCAN_DIV=8, DEAD=2, reset then ena=1 -> idx sequence 0..5 at 8 cycles/slot; an_n low for exactly 6 of 8 cycles per slot; frame_done every 48 cycles.
REQ-033 Inputs hh=8'h07, mm=8'h45, ss=8'h59, pm=1 held across a frame -> next frame shows 9,5,5,4,7,0 on idx0..5; dp_n=0 only in idx0.
REQ-034 ss changes from 8'h30 to 8'h31 at mid-frame (idx=2) -> the current frame still shows 0 on idx0; the next frame shows 1.
REQ-035 ss=8'h5C -> idx0 shows seg_n=7'b0111111.
REQ-036 ena=0 for 20 cycles at idx=3, cnt=5 -> outputs off, cnt/idx frozen; after ena=1, slot 3 completes its remaining 3 cycles.
REQ-037 hh=8'h01 with SEG7_LEADING_ZERO_BLANK_EN defined -> an_n[5]=1 for the whole slot; with the macro undefined -> digit 5 shows 7'b1000000.
